etapa_busqueda: RTL and testbench

Instruction-fetch stage of the MIPS32 datapath, directly upstream of `controlpath`. It holds the program counter and requests instructions from instruction memory over a req/ack handshake. Each fetched word is captured into an instruction register that drives `instruccion` and `CampoFuncion` into `controlpath`. The next PC is chosen from `selFuentePc`, which `controlpath` returns for the instruction currently being presented.

---
 rtl/etapa_busqueda.sv | 108 ++++++++++
 tb/tb_etapa_busqueda.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/etapa_busqueda.sv
// MIPS32 instruction-fetch stage: program counter, req/ack fetch from instruction
// memory and the instruction register presented to controlpath.
//
// state    | meaning
// INICIO   | just out of reset, no request yet
// PEDIR    | mem_req high at mem_dir = pc, waiting for mem_ack
// ENTREGAR | IR valid, waiting for instr_lista to advance pc
module etapa_busqueda #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic [31:0] mem_dir,
   input  logic        mem_ack,
   input  logic [31:0] mem_dato,
   output logic [5:0]  instruccion,
   output logic [5:0]  CampoFuncion,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] inmediato,
   output logic [31:0] pc,
   output logic [31:0] pc_mas4,
   output logic        instr_valida,
   input  logic        instr_lista,
   input  logic        selFuentePc,
   input  logic [31:0] desplazamiento
);

   typedef enum logic [1:0] {INICIO, PEDIR, ENTREGAR} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_ir;
   logic [31:0] r_pc;
   logic        w_ld_ir;
   logic        w_ld_pc;
   logic [31:0] w_offset;
   logic [31:0] w_pc_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= INICIO;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake outputs decode straight from state so an async reset drops them at once.
   always_comb begin
      w_state_nxt  = r_state;
      mem_req      = 1'b0;
      instr_valida = 1'b0;
      w_ld_ir      = 1'b0;
      w_ld_pc      = 1'b0;
      case (r_state)
         INICIO: begin
            w_state_nxt = PEDIR;
         end
         PEDIR: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               w_ld_ir     = 1'b1;
               w_state_nxt = ENTREGAR;
            end
         end
         ENTREGAR: begin
            instr_valida = 1'b1;
            if (instr_lista) begin
               w_ld_pc     = 1'b1;
               w_state_nxt = PEDIR;
            end
         end
         default: begin
            w_state_nxt = INICIO;
         end
      endcase
   end

   assign w_offset = desplazamiento << 2;
   assign pc_mas4  = r_pc + 32'd4;
   assign w_pc_nxt = (selFuentePc ? (pc_mas4 + w_offset) : pc_mas4) & 32'hFFFF_FFFC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ir <= 32'h0000_0000;
         r_pc <= {PC_RESET[31:2], 2'b00};
      end else begin
         if (w_ld_ir) begin
            r_ir <= mem_dato;
         end
         if (w_ld_pc) begin
            r_pc <= w_pc_nxt;
         end
      end
   end

   assign pc           = r_pc;
   assign mem_dir      = r_pc;
   assign instruccion  = r_ir[31:26];
   assign rs           = r_ir[25:21];
   assign rt           = r_ir[20:16];
   assign rd           = r_ir[15:11];
   assign inmediato    = r_ir[15:0];
   assign CampoFuncion = r_ir[5:0];

endmodule

// File: tb/tb_etapa_busqueda.sv
// Directed bench for etapa_busqueda: a scoreboard of expected IR/pc per fetch, plus
// a second instance with PC_RESET = 0xFFFF_FFFC to cover pc wrap-around.
module tb_etapa_busqueda;

   logic        clk;
   logic        rst_n;
   logic        mem_ack;
   logic [31:0] mem_dato;
   logic        instr_lista;
   logic        selFuentePc;
   logic [31:0] desplazamiento;

   logic        mem_req,   mem_req_w;
   logic [31:0] mem_dir,   mem_dir_w;
   logic [5:0]  instruccion, instruccion_w;
   logic [5:0]  CampoFuncion, CampoFuncion_w;
   logic [4:0]  rs, rt, rd, rs_w, rt_w, rd_w;
   logic [15:0] inmediato, inmediato_w;
   logic [31:0] pc, pc_w, pc_mas4, pc_mas4_w;
   logic        instr_valida, instr_valida_w;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_pc;
   int          checks = 0;
   int          errors = 0;

   etapa_busqueda #(.PC_RESET(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_dir(mem_dir),
      .mem_ack(mem_ack), .mem_dato(mem_dato), .instruccion(instruccion),
      .CampoFuncion(CampoFuncion), .rs(rs), .rt(rt), .rd(rd), .inmediato(inmediato),
      .pc(pc), .pc_mas4(pc_mas4), .instr_valida(instr_valida), .instr_lista(instr_lista),
      .selFuentePc(selFuentePc), .desplazamiento(desplazamiento)
   );

   etapa_busqueda #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req_w), .mem_dir(mem_dir_w),
      .mem_ack(mem_ack), .mem_dato(mem_dato), .instruccion(instruccion_w),
      .CampoFuncion(CampoFuncion_w), .rs(rs_w), .rt(rt_w), .rd(rd_w), .inmediato(inmediato_w),
      .pc(pc_w), .pc_mas4(pc_mas4_w), .instr_valida(instr_valida_w), .instr_lista(instr_lista),
      .selFuentePc(selFuentePc), .desplazamiento(desplazamiento)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while in PEDIR; returns at the negedge where IR is valid.
   task automatic fetch(input logic [31:0] word, input int waits);
      exp_t e;
      int   n;
      sb.push_back('{ir: word, pc: model_pc});
      for (int i = 0; i < waits; i++) begin
         chk("wait_req", {31'd0, mem_req}, 32'd1);
         chk("wait_dir", mem_dir, model_pc);
         chk("wait_valid", {31'd0, instr_valida}, 32'd0);
         @(negedge clk);
      end
      chk("req", {31'd0, mem_req}, 32'd1);
      chk("dir", mem_dir, model_pc);
      mem_ack  = 1'b1;
      mem_dato = word;
      @(negedge clk);
      mem_ack  = 1'b0;
      mem_dato = 32'hDEAD_BEEF;
      n = 0;
      while (!instr_valida && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("valid_latency", n, 0);
      chk("valid", {31'd0, instr_valida}, 32'd1);
      chk("req_low", {31'd0, mem_req}, 32'd0);
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk("opcode", {26'd0, instruccion}, {26'd0, e.ir[31:26]});
         chk("rs", {27'd0, rs}, {27'd0, e.ir[25:21]});
         chk("rt", {27'd0, rt}, {27'd0, e.ir[20:16]});
         chk("rd", {27'd0, rd}, {27'd0, e.ir[15:11]});
         chk("imm", {16'd0, inmediato}, {16'd0, e.ir[15:0]});
         chk("funct", {26'd0, CampoFuncion}, {26'd0, e.ir[5:0]});
         chk("pc", pc, e.pc);
         chk("pc_mas4", pc_mas4, e.pc + 32'd4);
      end
   endtask

   // Called at a negedge in ENTREGAR; returns at the negedge of the next PEDIR cycle.
   task automatic consume(input logic sel, input logic [31:0] desp);
      instr_lista    = 1'b1;
      selFuentePc    = sel;
      desplazamiento = desp;
      if (sel) model_pc = model_pc + 32'd4 + {desp[29:0], 2'b00};
      else     model_pc = model_pc + 32'd4;
      model_pc[1:0] = 2'b00;
      @(negedge clk);
      instr_lista    = 1'b0;
      selFuentePc    = 1'b1;
      desplazamiento = 32'h1234_5678;
      chk("next_req", {31'd0, mem_req}, 32'd1);
      chk("next_dir", mem_dir, model_pc);
   endtask

   initial begin
      rst_n = 1'b1; mem_ack = 1'b0; mem_dato = 32'h0; instr_lista = 1'b0;
      selFuentePc = 1'b0; desplazamiento = 32'h0; model_pc = 32'h0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valida}, 32'd0);
      chk("rst_dir", mem_dir, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc4", pc_mas4, 32'h4);
      chk("rst_opcode", {26'd0, instruccion}, 32'd0);
      chk("rst_funct", {26'd0, CampoFuncion}, 32'd0);
      chk("rst_fields", {rs, rt, rd, inmediato}, 32'd0);
      chk("rst_wrap_dir", mem_dir_w, 32'hFFFF_FFFC);
      chk("rst_wrap_pc4", pc_mas4_w, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("inicio_req", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      chk("first_req", {31'd0, mem_req}, 32'd1);
      chk("first_dir", mem_dir, 32'h0);

      // zero-wait lw at pc 0; wrap instance fetches at 0xFFFF_FFFC in parallel
      fetch(32'h8C22_0004, 0);
      chk("lw_opcode", {26'd0, instruccion}, 32'h23);
      chk("lw_rs", {27'd0, rs}, 32'd1);
      chk("lw_rt", {27'd0, rt}, 32'd2);
      chk("lw_imm", {16'd0, inmediato}, 32'h4);
      consume(1'b0, 32'h0);
      chk("wrap_dir", mem_dir_w, 32'h0000_0000);

      fetch(32'h2008_0005, 3);
      consume(1'b0, 32'h0);
      fetch(32'h1000_FFFF, 0);
      consume(1'b1, 32'hFFFF_FFFF);
      chk("beq_taken_dir", mem_dir, 32'd8);
      fetch(32'h1000_FFFF, 1);
      consume(1'b0, 32'hFFFF_FFFF);
      chk("beq_not_taken_dir", mem_dir, 32'd12);

      // downstream stall; stray ack/branch inputs must be ignored
      fetch(32'h0022_1820, 0);
      mem_ack = 1'b1;
      mem_dato = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_funct", {26'd0, CampoFuncion}, 32'h20);
         chk("stall_rd", {27'd0, rd}, 32'd3);
         chk("stall_pc", pc, 32'd12);
         chk("stall_req", {31'd0, mem_req}, 32'd0);
         chk("stall_valid", {31'd0, instr_valida}, 32'd1);
      end
      mem_ack = 1'b0;
      consume(1'b1, 32'h4000_0001);
      chk("trunc_offset_dir", mem_dir, 32'd20);

      // async reset in the middle of PEDIR
      #2 rst_n = 1'b0;
      #1;
      chk("async_req", {31'd0, mem_req}, 32'd0);
      chk("async_dir", mem_dir, 32'h0);
      chk("async_wrap_dir", mem_dir_w, 32'hFFFF_FFFC);
      chk("async_ir", {26'd0, instruccion}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("restart_req", {31'd0, mem_req}, 32'd1);
      chk("restart_dir", mem_dir, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete, expected finish before 20000");
      $fatal(1);
   end

endmodule
